lsu_sequencer: RTL and testbench
================================

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: the number of un-acknowledged cycles after which a memory beat is aborted (legal range 1..65535).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_req_valid, input, 1 bit: the current instruction is a load or store.
REQ-005 SHALL have port i_req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port i_req_addr, input, 32 bits: byte address from the ALU.
REQ-007 SHALL have port i_req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-008 SHALL have port i_req_mask, input, 5 bits: decoder mask; bit4 = unsigned load; bits3:0 = 0001 byte, 0011 half, 1111 word.
REQ-009 SHALL have port o_stall, output, 1 bit: holds PC and register-file writeback.
REQ-010 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port o_err, output, 1 bit: timeout flag, valid while o_done is high.
REQ-012 SHALL have port o_ld_data, output, 32 bits: extended load result, valid while o_done is high.
REQ-013 SHALL have ports o_mem_req (1 bit), o_mem_we (1 bit), o_mem_addr (32 bits, word-aligned), o_mem_wdata (32 bits) and o_mem_bmask (4 bits), all outputs: the memory request bus.
REQ-014 SHALL have ports i_mem_ack (1 bit) and i_mem_rdata (32 bits), both inputs: memory response, with rdata valid in the ack cycle.

Function
REQ-015 SHALL implement the states IDLE, BEAT0, BEAT1 and DONE.
REQ-016 In IDLE, a request (i_req_valid=1 and i_req_mask[3:0]!=0) SHALL drive o_stall high combinationally in the same cycle and latch addr, wdata, mask and we; the next state is BEAT0.
REQ-017 In IDLE, a request with i_req_mask[3:0]=0000 SHALL be ignored: no stall, no memory traffic.
REQ-018 o_stall SHALL stay high in BEAT0 and BEAT1 and go low in DONE; in DONE the block SHALL ignore i_req_valid and always return to IDLE on the next edge.
REQ-019 The 8-bit lane enable SHALL be mask[3:0] shifted left by addr[1:0], and the 64-bit data word SHALL be wdata shifted left by 8*addr[1:0].
REQ-020 In BEAT0, the memory bus SHALL carry: o_mem_addr = {addr[31:2],2'b00}, o_mem_bmask = lanes[3:0], o_mem_wdata = data[31:0].
REQ-021 In BEAT1, the memory bus SHALL carry: o_mem_addr = beat0 address + 4, o_mem_bmask = lanes[7:4], o_mem_wdata = data[63:32].
REQ-022 BEAT1 SHALL be entered only if lanes[7:4]!=0 (misaligned access crossing a word); otherwise BEAT0 SHALL go directly to DONE.
REQ-023 o_mem_req SHALL be registered, high throughout BEAT0/BEAT1 until the cycle i_mem_ack=1 is sampled, and all bus fields SHALL be stable while o_mem_req is high.
REQ-024 A beat SHALL complete in the cycle ack is sampled; minimum latency is request in cycle N, beat0 in N+1, DONE in N+2 (single beat) or N+3 (two beats).
REQ-025 i_mem_ack while o_mem_req is low SHALL be ignored.
REQ-026 For loads, the beat rdata SHALL be captured into a 64-bit buffer and the result SHALL be the buffer shifted right by 8*addr[1:0], then sign-extended from bit 7/15 (mask[4]=0) or zero-extended (mask[4]=1); word loads are not extended.
REQ-027 For stores, o_ld_data SHALL be 0 and mask[4] is don't-care.
REQ-028 A per-beat cycle counter SHALL clear at beat entry and increment each cycle with o_mem_req=1 and no ack.
REQ-029 When the counter reaches TIMEOUT_CYCLES, the beat SHALL be aborted (o_mem_req low next cycle), the FSM SHALL go to DONE with o_err=1 and o_ld_data=0, and BEAT1 SHALL be skipped.
REQ-030 An ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success.

Reset
REQ-031 With i_reset high at a clock edge, the state SHALL become IDLE, the counter and buffers SHALL clear, and all registered outputs SHALL be 0.
REQ-032 o_stall SHALL be 0 while i_reset is high.
REQ-033 A reset during BEAT0/BEAT1 SHALL drop o_mem_req on the following cycle with no o_done pulse; a late ack after reset SHALL be ignored.

Structure
REQ-034 Package lsu_pkg SHALL hold the state enum, the mask encodings (MASK_B, MASK_H, MASK_W, MASK_UNSIGNED_BIT) and the lane/offset widths.
REQ-035 Combinational sub-module lsu_align SHALL perform the lane shifting, the 64-bit store alignment and the load extraction/extension; the FSM, counter and registers SHALL stay in lsu_sequencer.

Verification
REQ-036 SW of 0xDEADBEEF at 0x100, ack after 2 wait cycles: bus addr 0x100, bmask 1111, wdata 0xDEADBEEF; o_done 4 cycles after the request; o_err=0.
REQ-037 LB at 0x203 with rdata 0x80FF_FF_FF, immediate ack: single beat with bmask 1000; o_ld_data = 0xFFFFFF80. LBU (mask 10001) of the same location: o_ld_data = 0x00000080.
REQ-038 LW at 0x302: beat0 at addr 0x300 with bmask 1100 returns 0x5678xxxx; beat1 at 0x304 with bmask 0011 returns 0xxxxx1234; o_ld_data = 0x12345678; done at N+3.
REQ-039 SH of 0xAABB at 0x403: beat0 at 0x400 with bmask 1000 and wdata[31:24]=0xBB; beat1 at 0x404 with bmask 0001 and wdata[7:0]=0xAA.
REQ-040 With TIMEOUT_CYCLES=4 and no ack: o_mem_req high for exactly 4 cycles, then o_done=1, o_err=1, o_ld_data=0, and BEAT1 is never issued.
REQ-041 Reset asserted in the second cycle of BEAT0: o_mem_req=0 and o_stall=0 the next cycle, no o_done pulse, and an ack 1 cycle later is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and encodings for the load/store sequencer
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  localparam int LANE_W = 8;
  localparam int OFF_W  = 2;
  localparam int CNT_W  = 16;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;
  localparam int MASK_UNSIGNED_BIT = 4;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane shifting, store alignment and load extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [OFF_W-1:0]  off_i,
  input  logic [4:0]        mask_i,
  input  logic [31:0]       wdata_i,
  input  logic [63:0]       buf_i,
  output logic [LANE_W-1:0] lanes_o,
  output logic [63:0]       data_o,
  output logic [31:0]       ld_data_o
);

  logic [63:0] shifted;
  logic        unsigned_ld;

  assign unsigned_ld = mask_i[MASK_UNSIGNED_BIT];

  always_comb begin
    lanes_o   = {4'b0000, mask_i[3:0]} << off_i;
    data_o    = {32'h0, wdata_i} << {off_i, 3'b000};
    shifted   = buf_i >> {off_i, 3'b000};
    ld_data_o = shifted[31:0];
    case (mask_i[3:0])
      MASK_B:  ld_data_o = unsigned_ld ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      MASK_H:  ld_data_o = unsigned_ld ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data_o = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// rtl/lsu_sequencer.sv - splits a load/store into one or two word beats with timeout
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_mask,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_ld_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [CNT_W-1:0] TMO_L = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        mask_q, mask_d;
  logic              we_q, we_d;
  logic              mem_req_q, mem_req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       buf_q, buf_d;
  logic              err_q, err_d;

  logic [LANE_W-1:0] lanes;
  logic [63:0]       data64;
  logic [31:0]       ld_ext;
  logic              req_hit, acked, tmo, in_beat;
  logic [31:0]       beat0_addr;

  lsu_align u_align (
    .off_i     (addr_q[OFF_W-1:0]),
    .mask_i    (mask_q),
    .wdata_i   (wdata_q),
    .buf_i     (buf_q),
    .lanes_o   (lanes),
    .data_o    (data64),
    .ld_data_o (ld_ext)
  );

  assign req_hit    = i_req_valid && (i_req_mask[3:0] != 4'b0000);
  assign acked      = mem_req_q && i_mem_ack;
  // Ack on the final counted cycle wins over the timeout.
  assign tmo        = mem_req_q && !i_mem_ack && ((cnt_q + 1'b1) == TMO_L);
  assign in_beat    = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign beat0_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    we_d      = we_q;
    mem_req_d = mem_req_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hit) begin
          addr_d    = i_req_addr;
          wdata_d   = i_req_wdata;
          mask_d    = i_req_mask;
          we_d      = i_req_we;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          buf_d     = '0;
          err_d     = 1'b0;
          state_d   = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (acked) begin
          buf_d[31:0] = i_mem_rdata;
          cnt_d       = '0;
          if (lanes[7:4] != 4'b0000) begin
            state_d = ST_BEAT1;
          end else begin
            mem_req_d = 1'b0;
            state_d   = ST_DONE;
          end
        end else if (tmo) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BEAT1: begin
        if (acked) begin
          buf_d[63:32] = i_mem_rdata;
          mem_req_d    = 1'b0;
          state_d      = ST_DONE;
        end else if (tmo) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      we_q      <= 1'b0;
      mem_req_q <= 1'b0;
      cnt_q     <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      we_q      <= we_d;
      mem_req_q <= mem_req_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
    end
  end

  assign o_stall     = !i_reset && (in_beat || ((state_q == ST_IDLE) && req_hit));
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = o_done && err_q;
  assign o_ld_data   = (o_done && !we_q && !err_q) ? ld_ext : 32'h0;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = in_beat && we_q;
  assign o_mem_addr  = (state_q == ST_BEAT0) ? beat0_addr :
                       (state_q == ST_BEAT1) ? beat0_addr + 32'd4 : 32'h0;
  assign o_mem_bmask = (state_q == ST_BEAT0) ? lanes[3:0] :
                       (state_q == ST_BEAT1) ? lanes[7:4] : 4'h0;
  assign o_mem_wdata = (state_q == ST_BEAT0) ? data64[31:0] :
                       (state_q == ST_BEAT1) ? data64[63:32] : 32'h0;

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb/tb_lsu_sequencer.sv - directed and random checks of lsu_sequencer against a byte-level model
module tb_lsu_sequencer;
  import lsu_pkg::*;

  localparam int TMO = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [4:0]  i_req_mask;
  logic        o_stall, o_done, o_err;
  logic [31:0] o_ld_data;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  int tnum = 0;

  lsu_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .i_req_mask  (i_req_mask),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_ld_data   (o_ld_data),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_bmask (o_mem_bmask),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (txn %0d): observed %h expected %h", tag, tnum, obs, exp);
    end
  endtask

  // Byte-level model: byte k of the access lives at address addr+k, in the
  // beat whose word differs from the first word, at lane (addr+k)%4.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [4:0] mask, input int d0, input int d1,
                     input logic [31:0] rd0, input logic [31:0] rd1);
    logic [3:0]  bm   [2];
    logic [31:0] wexp [2];
    logic [31:0] rd   [2];
    logic [31:0] badr [2];
    int          dly  [2];
    logic [31:0] res, ba, lm;
    int size, nb, bt, ln;
    bit err, acked;
    tnum++;
    rd[0] = rd0; rd[1] = rd1; dly[0] = d0; dly[1] = d1;
    bm[0] = 4'h0; bm[1] = 4'h0; wexp[0] = 32'h0; wexp[1] = 32'h0; res = 32'h0;
    size = (mask[3:0] == MASK_B) ? 1 : (mask[3:0] == MASK_H) ? 2 : 4;
    nb = 1;
    for (int k = 0; k < size; k++) begin
      ba = addr + 32'(k);
      bt = ((ba >> 2) != (addr >> 2)) ? 1 : 0;
      ln = int'(ba[1:0]);
      if (bt == 1) nb = 2;
      bm[bt][ln] = 1'b1;
      wexp[bt][ln*8 +: 8] = wdata[k*8 +: 8];
      res[k*8 +: 8] = rd[bt][ln*8 +: 8];
    end
    if (size == 1 && !mask[4]) res = {{24{res[7]}}, res[7:0]};
    if (size == 2 && !mask[4]) res = {{16{res[15]}}, res[15:0]};
    badr[0] = addr & 32'hFFFF_FFFC;
    badr[1] = badr[0] + 32'd4;

    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr;
    i_req_wdata = wdata; i_req_mask = mask;
    #1 chk("stall_on_request", o_stall, 1'b1);
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_wdata = $urandom;
    i_req_mask = 5'(($urandom % 32)); i_req_we = 1'($urandom % 2);
    err = 1'b0;
    for (int b = 0; b < nb && !err; b++) begin
      acked = 1'b0;
      for (int w = 0; w < TMO && !acked && !err; w++) begin
        chk("mem_req_high", o_mem_req, 1'b1);
        chk("stall_in_beat", o_stall, 1'b1);
        chk("no_done_in_beat", o_done, 1'b0);
        chk("bus_addr", o_mem_addr, badr[b]);
        chk("bus_bmask", o_mem_bmask, bm[b]);
        chk("bus_we", o_mem_we, we);
        if (we) begin
          lm = {{8{bm[b][3]}}, {8{bm[b][2]}}, {8{bm[b][1]}}, {8{bm[b][0]}}};
          chk("bus_wdata", o_mem_wdata & lm, wexp[b]);
        end
        if (w == dly[b]) begin
          i_mem_ack = 1'b1; i_mem_rdata = rd[b];
          acked = 1'b1;
        end else if (w == TMO - 1) begin
          err = 1'b1;
        end
        @(negedge i_clk);
        i_mem_ack = 1'b0; i_mem_rdata = $urandom;
      end
    end
    chk("done_pulse", o_done, 1'b1);
    chk("err_flag", o_err, err);
    chk("ld_data", o_ld_data, (err || we) ? 32'h0 : res);
    chk("stall_in_done", o_stall, 1'b0);
    chk("mem_req_low_in_done", o_mem_req, 1'b0);
    @(negedge i_clk);
    chk("done_one_cycle", o_done, 1'b0);
    chk("no_beat_after_done", o_mem_req, 1'b0);
    chk("stall_idle", o_stall, 1'b0);
  endtask

  initial begin
    i_reset = 1'b1; i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h0;
    i_req_wdata = 32'h0; i_req_mask = {1'b0, MASK_W}; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    repeat (3) @(negedge i_clk);
    chk("reset_stall", o_stall, 1'b0);
    chk("reset_done", o_done, 1'b0);
    chk("reset_mem_req", o_mem_req, 1'b0);
    chk("reset_err", o_err, 1'b0);
    chk("reset_ld_data", o_ld_data, 32'h0);
    i_reset = 1'b0; i_req_valid = 1'b0;
    @(negedge i_clk);

    txn(1'b1, 32'h100, 32'hDEADBEEF, {1'b0, MASK_W}, 2, 0, 32'h0, 32'h0);
    txn(1'b0, 32'h203, 32'h0, {1'b0, MASK_B}, 0, 0, 32'h80FFFFFF, 32'h0);
    txn(1'b0, 32'h203, 32'h0, {1'b1, MASK_B}, 0, 0, 32'h80FFFFFF, 32'h0);
    txn(1'b0, 32'h302, 32'h0, {1'b0, MASK_W}, 0, 0, 32'h5678AAAA, 32'hBBBB1234);
    txn(1'b1, 32'h403, 32'h0000AABB, {1'b0, MASK_H}, 0, 1, 32'h0, 32'h0);
    txn(1'b0, 32'h302, 32'h0, {1'b0, MASK_W}, 9, 0, 32'h5678AAAA, 32'hBBBB1234);
    txn(1'b0, 32'h501, 32'h0, {1'b0, MASK_W}, 3, 3, 32'hCAFEF00D, 32'h01234567);
    txn(1'b0, 32'h502, 32'h0, {1'b0, MASK_W}, 1, 7, 32'h11223344, 32'h55667788);

    // Zero-mask request and stray ack in idle are both ignored.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_mask = 5'b10000; i_mem_ack = 1'b1;
    #1 chk("zero_mask_no_stall", o_stall, 1'b0);
    @(negedge i_clk);
    i_req_valid = 1'b0; i_mem_ack = 1'b0;
    chk("zero_mask_no_req", o_mem_req, 1'b0);
    chk("zero_mask_no_done", o_done, 1'b0);
    @(negedge i_clk);
    chk("stray_ack_no_done", o_done, 1'b0);

    // Reset in the second cycle of beat0.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h600; i_req_mask = {1'b0, MASK_W};
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("rst_beat0_req", o_mem_req, 1'b1);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1 chk("stall_low_in_reset", o_stall, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("rst_drops_req", o_mem_req, 1'b0);
    chk("rst_stall_low", o_stall, 1'b0);
    chk("rst_no_done", o_done, 1'b0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    chk("late_ack_no_done", o_done, 1'b0);
    chk("late_ack_no_req", o_mem_req, 1'b0);
    @(negedge i_clk);
    chk("late_ack_still_idle", o_done, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] m4;
      case ($urandom % 3)
        0:       m4 = MASK_B;
        1:       m4 = MASK_H;
        default: m4 = MASK_W;
      endcase
      txn(1'($urandom % 2), $urandom, $urandom, {1'($urandom % 2), m4},
          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
